// File: rtl/mult_clk_wake_ctrl.sv
// mult_clk_wake_ctrl
//   Multiplier-side end of the clock-gating handshake. Raises the multiplier ICG
//   enable on a multiply request and grants issue only once the gated clock has
//   run WAKE_CYCLES. The clock stays on while results are outstanding and for
//   HOLD_CYCLES idle cycles afterwards, then it is gated off again.
//
// Ports
//   clk_i                free-running core clock
//   rst_ni               asynchronous reset, active low
//   mult_req_i           issue stage holds a multiply op this cycle
//   mult_issue_i         op handed to the multiplier this cycle
//   mult_result_valid_i  multiplier retires one result this cycle
//   flush_i              pipeline flush, outstanding results are discarded
//   clk_en_o             ICG enable (registered)
//   mult_ready_o         clock stable and an in-flight slot is free (registered)
//   busy_o               controller is not OFF (registered)
//   gated_cycles_o       cycles spent with clk_en_o==0
//
// Build option
//   MULT_CLK_STATS_EN    when defined, gated_cycles_o is a saturating counter of
//                        gated cycles; otherwise it is tied to zero.
//
// state | meaning
// ------+-------------------------------------------------------------
// OFF   | multiplier clock gated, waiting for a request
// WAKE  | clock enabled, counting down the settle time, no issue yet
// ON    | clock running, tracking in-flight ops, issue allowed if a slot is free
// HOLD  | nothing in flight, clock kept on for a grace period before gating

module mult_clk_wake_ctrl #(
  parameter int WAKE_CYCLES  = 2,
  parameter int HOLD_CYCLES  = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mult_req_i,
  input  logic        mult_issue_i,
  input  logic        mult_result_valid_i,
  input  logic        flush_i,
  output logic        clk_en_o,
  output logic        mult_ready_o,
  output logic        busy_o,
  output logic [31:0] gated_cycles_o
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0] MAX_CNT = IW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [2:0]    wake_cnt_q, wake_cnt_d;
  logic [3:0]    hold_cnt_q, hold_cnt_d;
  logic          clk_en_q, clk_en_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  logic          inc, dec, idle;
  logic [IW-1:0] inflight_nx;

  always_comb begin
    // A result only counts if something is outstanding; an issue is only
    // accepted below the limit unless a result frees a slot the same cycle.
    dec = mult_result_valid_i && (inflight_q != '0);
    inc = mult_issue_i && ((inflight_q < MAX_CNT) || dec);
    inflight_nx = flush_i ? '0 : (inflight_q + IW'(inc) - IW'(dec));
    idle = (inflight_nx == '0) && !mult_req_i && !mult_issue_i;

    state_d    = state_q;
    inflight_d = inflight_q;
    wake_cnt_d = wake_cnt_q;
    hold_cnt_d = hold_cnt_q;
    clk_en_d   = clk_en_q;
    ready_d    = ready_q;

    case (state_q)
      ST_OFF: begin
        clk_en_d   = 1'b0;
        ready_d    = 1'b0;
        inflight_d = '0;
        if (mult_req_i) begin
          state_d    = ST_WAKE;
          clk_en_d   = 1'b1;
          wake_cnt_d = 3'(WAKE_CYCLES - 1);
        end
      end
      ST_WAKE: begin
        // Request drop and flush are ignored: the wake always completes.
        if (wake_cnt_q == '0) begin
          state_d = ST_ON;
          ready_d = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q - 3'd1;
        end
      end
      ST_ON: begin
        inflight_d = inflight_nx;
        if (idle) begin
          if (HOLD_CYCLES != 0) begin
            state_d    = ST_HOLD;
            hold_cnt_d = 4'(HOLD_CYCLES - 1);
            ready_d    = 1'b1;
          end else begin
            state_d  = ST_OFF;
            clk_en_d = 1'b0;
            ready_d  = 1'b0;
          end
        end else begin
          ready_d = (inflight_nx < MAX_CNT);
        end
      end
      ST_HOLD: begin
        inflight_d = inflight_nx;
        if (mult_req_i || mult_issue_i) begin
          state_d    = ST_ON;
          hold_cnt_d = '0;
          ready_d    = (inflight_nx < MAX_CNT);
        end else if (hold_cnt_q == '0) begin
          state_d  = ST_OFF;
          clk_en_d = 1'b0;
          ready_d  = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d  = ST_OFF;
        clk_en_d = 1'b0;
        ready_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_OFF);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_OFF;
      inflight_q <= '0;
      wake_cnt_q <= '0;
      hold_cnt_q <= '0;
      clk_en_q   <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      wake_cnt_q <= wake_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      clk_en_q   <= clk_en_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign clk_en_o     = clk_en_q;
  assign mult_ready_o = ready_q;
  assign busy_o       = busy_q;

`ifdef MULT_CLK_STATS_EN
  logic [31:0] gated_q, gated_d;

  always_comb begin
    gated_d = gated_q;
    if (!clk_en_q && (gated_q != 32'hFFFF_FFFF)) begin
      gated_d = gated_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gated_q <= '0;
    end else begin
      gated_q <= gated_d;
    end
  end

  assign gated_cycles_o = gated_q;
`else
  assign gated_cycles_o = 32'h0;
`endif

`ifndef SYNTHESIS
  // Issue is only legal while ready is shown.
  a_issue_when_ready : assert property (@(posedge clk_i) disable iff (!rst_ni)
    mult_issue_i |-> mult_ready_o);

  // A result with nothing outstanding is only expected as a leftover from a flush.
  a_result_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mult_result_valid_i && (inflight_q == '0)) |-> (flush_i || $past(flush_i)));

  a_ready_after_clk : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $rose(mult_ready_o) |-> $past(clk_en_o));
`endif

endmodule

// File: tb/tb_mult_clk_wake_ctrl.sv
module tb_mult_clk_wake_ctrl;

  localparam int WAKE = 2;
  localparam int HOLD = 4;
  localparam int MAXI = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        issue = 1'b0;
  logic        res = 1'b0;
  logic        flush = 1'b0;
  logic        clk_en;
  logic        ready;
  logic        busy;
  logic [31:0] gated;

  int checks = 0;
  int failures = 0;

  // Reference model: the clock is either powered or not; once powered it has an
  // age (cycles since enable) and a run of consecutive idle cycles.
  int          m_powered;
  int          m_age;
  int          m_inf;
  int          m_idle;
  int unsigned m_gated;

  always #5 clk = ~clk;

  mult_clk_wake_ctrl #(
    .WAKE_CYCLES (WAKE),
    .HOLD_CYCLES (HOLD),
    .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .mult_req_i         (req),
    .mult_issue_i       (issue),
    .mult_result_valid_i(res),
    .flush_i            (flush),
    .clk_en_o           (clk_en),
    .mult_ready_o       (ready),
    .busy_o             (busy),
    .gated_cycles_o     (gated)
  );

  function automatic void m_reset();
    m_powered = 0;
    m_age     = 0;
    m_inf     = 0;
    m_idle    = 0;
    m_gated   = 0;
  endfunction

  function automatic int m_ready();
    if (m_powered == 0 || m_age < WAKE) return 0;
    if (m_idle > 0) return 1;
    return (m_inf < MAXI) ? 1 : 0;
  endfunction

  function automatic void m_step();
    int nxt;
    if (m_powered == 0) m_gated++;
    if (m_powered == 0) begin
      if (req) begin
        m_powered = 1;
        m_age     = 0;
        m_idle    = 0;
        m_inf     = 0;
      end
    end else if (m_age < WAKE) begin
      m_age++;
    end else begin
      nxt = m_inf + int'(issue) - ((res && m_inf > 0) ? 1 : 0);
      if (nxt > MAXI) nxt = MAXI;
      if (flush) nxt = 0;
      m_inf = nxt;
      if (nxt == 0 && !req && !issue) m_idle++;
      else m_idle = 0;
      if (m_idle > HOLD) begin
        m_powered = 0;
        m_idle    = 0;
        m_inf     = 0;
        m_age     = 0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("clk_en_o", 32'(clk_en), 32'(m_powered));
    chk("mult_ready_o", 32'(ready), 32'(m_ready()));
    chk("busy_o", 32'(busy), 32'(m_powered));
`ifdef MULT_CLK_STATS_EN
    chk("gated_cycles_o", gated, m_gated);
`else
    chk("gated_cycles_o", gated, 32'h0);
`endif
  endtask

  // One clock: drive inputs, advance the model on the edge, check just after.
  task automatic cyc(input logic r, input logic i, input logic v, input logic f);
    req   = r;
    issue = i;
    res   = v;
    flush = f;
    @(posedge clk);
    m_step();
    #1;
    check_outs();
  endtask

  // Reset asserted mid-cycle: outputs must drop before the next edge.
  task automatic mid_reset();
    req   = 1'b0;
    issue = 1'b0;
    res   = 1'b0;
    flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_outs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_outs();
  endtask

  initial begin
    int lat;
    int cnt;
    logic req_mode;
    logic r, i, v, f;

    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outs();
    rst_n = 1'b1;

    // 1: idle after reset
    repeat (10) cyc(0, 0, 0, 0);
`ifdef MULT_CLK_STATS_EN
    chk("gated_after_10", gated, 32'd10);
`else
    chk("gated_tied_zero", gated, 32'd0);
`endif

    // 2: wake latency, one op, hold length
    cyc(1, 0, 0, 0);
    chk("clk_en_rise", 32'(clk_en), 32'd1);
    lat = 0;
    while (ready !== 1'b1 && lat < 20) begin
      cyc(1, 0, 0, 0);
      lat++;
    end
    chk("wake_latency", 32'(lat), 32'(WAKE));
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("hold_clk_on", 32'(clk_en), 32'd1);
    cnt = 0;
    while (clk_en === 1'b1 && cnt < 30) begin
      cyc(0, 0, 0, 0);
      cnt++;
    end
    chk("hold_length", 32'(cnt), 32'(HOLD));
    chk("busy_after_hold", 32'(busy), 32'd0);

    // 3: fill to MAX_INFLIGHT
    repeat (WAKE + 1) cyc(1, 0, 0, 0);
    repeat (MAXI) cyc(1, 1, 0, 0);
    chk("ready_full", 32'(ready), 32'd0);
    cyc(1, 0, 1, 0);
    chk("ready_after_result", 32'(ready), 32'd1);
    cyc(1, 1, 1, 0);
    chk("ready_issue_and_result", 32'(ready), 32'd1);
    cyc(1, 1, 0, 0);
    chk("ready_full_again", 32'(ready), 32'd0);
    repeat (MAXI) cyc(0, 0, 1, 0);

    // 4: re-request late in HOLD, no re-wake
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("hold_to_on_clk", 32'(clk_en), 32'd1);
    chk("hold_to_on_ready", 32'(ready), 32'd1);
    cnt = 0;
    while (clk_en === 1'b1 && cnt < 30) begin
      cyc(0, 0, 0, 0);
      cnt++;
    end
    chk("off_after_rehold", 32'(clk_en), 32'd0);

    // 5: flush with two ops outstanding, then a late result
    repeat (WAKE + 1) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    cnt = 1;
    while (clk_en === 1'b1 && cnt < 30) begin
      cyc(0, 0, 0, 0);
      cnt++;
    end
    chk("flush_hold_length", 32'(cnt), 32'(HOLD));

    // 6: async reset during WAKE and during ON with three outstanding
    cyc(1, 0, 0, 0);
    mid_reset();
    cyc(0, 0, 0, 0);
    repeat (WAKE + 1) cyc(1, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0);
    mid_reset();
    cyc(0, 0, 0, 0);
    chk("off_after_reset", 32'(busy), 32'd0);

    // Random traffic against the model
    req_mode = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) req_mode = ~req_mode;
      r = req_mode;
      i = r && (m_ready() != 0) && ($urandom_range(0, 1) == 1);
      v = (m_inf > 0) && ($urandom_range(0, 9) < 4);
      f = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) mid_reset();
      else cyc(r, i, v, f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
